// File: rtl/mem_io_ctrl_if.sv
// CPU-side memory bus between the processor and mem_io_ctrl.
// The CPU drives the command/address/data; the controller answers with data and a ready pulse.
interface mem_io_ctrl_if #(
   parameter int DW = 16,
   parameter int AW = 9
) ();
   logic [1:0]    mem_cmd;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_ready;

   modport master (
      output mem_cmd, mem_addr, mem_wdata,
      input  mem_rdata, mem_ready
   );

   modport slave (
      input  mem_cmd, mem_addr, mem_wdata,
      output mem_rdata, mem_ready
   );
endinterface

// File: rtl/mem_io_ctrl.sv
// CPU memory controller: decodes each command into a RAM, LED, switch or unmapped access
// and sequences it with an IDLE/ACCESS/RESP machine that waits out the RAM read latency.
module mem_io_ctrl #(
   parameter int            DW       = 16,
   parameter int            AW       = 9,
   parameter int            RAM_AW   = 8,
   parameter int            RD_LAT   = 1,
   parameter int            LED_W    = 10,
   parameter int            SW_W     = 10,
   parameter logic [AW-1:0] LED_ADDR = 9'h100,
   parameter logic [AW-1:0] SW_ADDR  = 9'h140
) (
   input  logic              clk,
   input  logic              reset,
   mem_io_ctrl_if.slave      bus,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [DW-1:0]     ram_wdata,
   output logic              ram_we,
   input  logic [DW-1:0]     ram_rdata,
   input  logic [SW_W-1:0]   sw,
   output logic [LED_W-1:0]  ledr,
   output logic              bus_err
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   localparam logic [2:0] LAT_LOAD = 3'(RD_LAT - 1);

   state_t          state, state_next;
   logic [2:0]      lat_cnt, lat_cnt_next;
   logic            lat_write;
   logic [AW-1:0]   lat_addr;
   logic [DW-1:0]   lat_wdata;
   logic [DW-1:0]   hold;
   logic [DW-1:0]   rd_mux;
   logic [SW_W-1:0] sw_meta, sw_sync;
   logic            start, access_done;
   logic            is_ram, is_led, is_sw, unmapped;

   assign start    = (bus.mem_cmd == 2'b01) || (bus.mem_cmd == 2'b10);
   assign is_ram   = ~lat_addr[AW-1];
   assign is_led   = ~is_ram && (lat_addr == LED_ADDR);
   assign is_sw    = ~is_ram && (lat_addr == SW_ADDR);
   assign unmapped = ~is_ram && ~is_led && ~is_sw;

   assign ram_addr  = lat_addr[RAM_AW-1:0];
   assign ram_wdata = lat_wdata;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         lat_cnt <= '0;
      end else begin
         state   <= state_next;
         lat_cnt <= lat_cnt_next;
      end
   end

   // Only a RAM read waits on the counter; every other access leaves ACCESS after one cycle.
   always_comb begin
      state_next    = state;
      lat_cnt_next  = lat_cnt;
      access_done   = 1'b0;
      bus.mem_ready = 1'b0;
      ram_we        = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_next   = ACCESS;
               lat_cnt_next = LAT_LOAD;
            end
         end
         ACCESS: begin
            ram_we = lat_write && is_ram;
            if (lat_write || !is_ram || lat_cnt == 3'd0) begin
               access_done = 1'b1;
               state_next  = RESP;
            end else begin
               lat_cnt_next = lat_cnt - 3'd1;
            end
         end
         RESP: begin
            bus.mem_ready = 1'b1;
            state_next    = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      rd_mux = '0;
      if (is_ram) begin
         rd_mux = ram_rdata;
      end else if (is_sw) begin
         rd_mux[SW_W-1:0] = sw_sync;
      end else if (is_led) begin
         rd_mux[LED_W-1:0] = ledr;
      end
   end

   // Writes leave the holding register untouched, so the last read value stays visible.
   assign bus.mem_rdata = (state == RESP && !lat_write) ? rd_mux : hold;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lat_write <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
      end else if (state == IDLE && start) begin
         lat_write <= (bus.mem_cmd == 2'b10);
         lat_addr  <= bus.mem_addr;
         lat_wdata <= bus.mem_wdata;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ledr    <= '0;
         bus_err <= 1'b0;
         hold    <= '0;
         sw_meta <= '0;
         sw_sync <= '0;
      end else begin
         sw_meta <= sw;
         sw_sync <= sw_meta;
         if (access_done && lat_write && is_led) begin
            ledr <= lat_wdata[LED_W-1:0];
         end
         if (access_done && unmapped) begin
            bus_err <= 1'b1;
         end
         if (state == RESP) begin
            hold <= bus.mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Bench for mem_io_ctrl: two instances (RAM read latency 1 and 3) with behavioural RAMs,
// a directed vector table, randomized traffic against a reference model, and reset/hold sequences.
module tb_mem_io_ctrl;

   typedef struct {
      int          sel;
      logic [1:0]  cmd;
      logic [8:0]  addr;
      logic [15:0] wdata;
      logic [15:0] exp_rdata;
      int          exp_lat;
      int          exp_we;
      logic [9:0]  exp_led;
      logic        exp_err;
   } vec_t;

   localparam logic [1:0] CMD_NONE  = 2'b00;
   localparam logic [1:0] CMD_READ  = 2'b01;
   localparam logic [1:0] CMD_WRITE = 2'b10;

   logic       clk = 1'b0;
   logic       reset;
   logic [9:0] sw;

   always #5 clk = ~clk;

   mem_io_ctrl_if #(.DW(16), .AW(9)) bus1 ();
   mem_io_ctrl_if #(.DW(16), .AW(9)) bus3 ();

   logic [7:0]  ram_addr1, ram_addr3;
   logic [15:0] ram_wdata1, ram_wdata3, ram_rdata1, ram_rdata3;
   logic        ram_we1, ram_we3, bus_err1, bus_err3;
   logic [9:0]  ledr1, ledr3;

   mem_io_ctrl #(.DW(16), .AW(9), .RAM_AW(8), .RD_LAT(1), .LED_W(10), .SW_W(10),
                 .LED_ADDR(9'h100), .SW_ADDR(9'h140)) dut1 (
      .clk(clk), .reset(reset), .bus(bus1),
      .ram_addr(ram_addr1), .ram_wdata(ram_wdata1), .ram_we(ram_we1), .ram_rdata(ram_rdata1),
      .sw(sw), .ledr(ledr1), .bus_err(bus_err1)
   );

   mem_io_ctrl #(.DW(16), .AW(9), .RAM_AW(8), .RD_LAT(3), .LED_W(10), .SW_W(10),
                 .LED_ADDR(9'h100), .SW_ADDR(9'h140)) dut3 (
      .clk(clk), .reset(reset), .bus(bus3),
      .ram_addr(ram_addr3), .ram_wdata(ram_wdata3), .ram_we(ram_we3), .ram_rdata(ram_rdata3),
      .sw(sw), .ledr(ledr3), .bus_err(bus_err3)
   );

   // Synchronous RAMs: address sampled at an edge, data out after 1 or 3 edges.
   logic [15:0] ram_mem1 [256];
   logic [15:0] ram_mem3 [256];
   logic [15:0] pipe1;
   logic [15:0] pipe3 [3];

   always @(posedge clk) begin
      if (ram_we1) ram_mem1[ram_addr1] <= ram_wdata1;
      pipe1 <= ram_mem1[ram_addr1];
   end

   always @(posedge clk) begin
      if (ram_we3) ram_mem3[ram_addr3] <= ram_wdata3;
      pipe3[0] <= ram_mem3[ram_addr3];
      pipe3[1] <= pipe3[0];
      pipe3[2] <= pipe3[1];
   end

   assign ram_rdata1 = pipe1;
   assign ram_rdata3 = pipe3[2];

   int          errors = 0;
   int          checks = 0;
   logic [15:0] ref_ram [2][16];
   logic [9:0]  ref_led [2];
   logic        ref_err [2];
   logic [9:0]  ref_sw;
   vec_t        tbl [13];

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic drive(input int sel, input logic [1:0] cmd, input logic [8:0] addr, input logic [15:0] wdata);
      if (sel == 0) begin
         bus1.mem_cmd = cmd; bus1.mem_addr = addr; bus1.mem_wdata = wdata;
      end else begin
         bus3.mem_cmd = cmd; bus3.mem_addr = addr; bus3.mem_wdata = wdata;
      end
   endtask

   task automatic sample(input int sel, output logic rdy, output logic [15:0] rd, output logic we,
                         output logic [7:0] ra, output logic [15:0] rw, output logic [9:0] led,
                         output logic err);
      if (sel == 0) begin
         rdy = bus1.mem_ready; rd = bus1.mem_rdata; we = ram_we1; ra = ram_addr1;
         rw = ram_wdata1; led = ledr1; err = bus_err1;
      end else begin
         rdy = bus3.mem_ready; rd = bus3.mem_rdata; we = ram_we3; ra = ram_addr3;
         rw = ram_wdata3; led = ledr3; err = bus_err3;
      end
   endtask

   // One transaction: present the command for one edge, then watch until mem_ready (bounded).
   task automatic apply_stimulus(input vec_t v, output logic [15:0] rd_pulse, output logic [15:0] rd_after,
                                 output int lat, output int we_cnt, output logic [7:0] we_addr,
                                 output logic [15:0] we_data, output logic [9:0] led, output logic err);
      logic rdy, we;
      logic [15:0] rd, rw;
      logic [7:0] ra;
      logic [9:0] l;
      logic e;
      rd_pulse = 'x; led = 'x; err = 'x; we_addr = 'x; we_data = 'x;
      @(negedge clk);
      drive(v.sel, v.cmd, v.addr, v.wdata);
      @(posedge clk);
      #1 drive(v.sel, CMD_NONE, v.addr, v.wdata);
      lat = 0; we_cnt = 0; rdy = 1'b0;
      while (!rdy && lat < 20) begin
         @(negedge clk);
         lat++;
         sample(v.sel, rdy, rd, we, ra, rw, l, e);
         if (we) begin we_cnt++; we_addr = ra; we_data = rw; end
         if (rdy) begin rd_pulse = rd; led = l; err = e; end
      end
      @(negedge clk);
      sample(v.sel, rdy, rd_after, we, ra, rw, l, e);
      if (we) we_cnt++;
   endtask

   task automatic run_vector(input vec_t v, input string tag);
      logic [15:0] rd_pulse, rd_after, we_data;
      logic [7:0]  we_addr;
      logic [9:0]  led;
      logic        err;
      int          lat, we_cnt;
      apply_stimulus(v, rd_pulse, rd_after, lat, we_cnt, we_addr, we_data, led, err);
      check_output({tag, " latency"}, lat, v.exp_lat);
      check_output({tag, " ram_we cycles"}, we_cnt, v.exp_we);
      if (v.exp_we != 0) begin
         check_output({tag, " ram_addr"}, we_addr, {24'h0, v.addr[7:0]});
         check_output({tag, " ram_wdata"}, we_data, v.wdata);
      end
      if (v.cmd == CMD_READ) begin
         check_output({tag, " rdata"}, rd_pulse, v.exp_rdata);
         check_output({tag, " rdata held"}, rd_after, v.exp_rdata);
      end
      check_output({tag, " ledr"}, led, v.exp_led);
      check_output({tag, " bus_err"}, err, v.exp_err);
   endtask

   // Reference model: applies the access rules to plain arrays and derives expectations.
   task automatic model_txn(input int sel, input logic [1:0] cmd, input logic [8:0] addr,
                            input logic [15:0] wdata, output vec_t v);
      bit to_ram, to_led, to_sw;
      int rd_lat;
      rd_lat = (sel == 0) ? 1 : 3;
      to_ram = (addr < 9'd256);
      to_led = (addr == 9'h100);
      to_sw  = (addr == 9'h140);
      v.sel = sel; v.cmd = cmd; v.addr = addr; v.wdata = wdata; v.exp_rdata = 16'h0;
      if (cmd == CMD_WRITE) begin
         if (to_ram) ref_ram[sel][addr[3:0]] = wdata;
         else if (to_led) ref_led[sel] = wdata[9:0];
         else if (!to_sw) ref_err[sel] = 1'b1;
      end else begin
         if (to_ram) v.exp_rdata = ref_ram[sel][addr[3:0]];
         else if (to_led) v.exp_rdata = {6'h0, ref_led[sel]};
         else if (to_sw) v.exp_rdata = {6'h0, ref_sw};
         else ref_err[sel] = 1'b1;
      end
      v.exp_lat = (cmd == CMD_READ && to_ram) ? rd_lat + 1 : 2;
      v.exp_we  = (cmd == CMD_WRITE && to_ram) ? 1 : 0;
      v.exp_led = ref_led[sel];
      v.exp_err = ref_err[sel];
   endtask

   initial begin
      logic rdy, we, err;
      logic [15:0] rd, rw;
      logic [7:0] ra;
      logic [9:0] led;
      logic [8:0] addr;
      vec_t v;
      int pulses;

      tbl[0]  = '{0, CMD_WRITE, 9'h005, 16'hBEEF, 16'h0000, 2, 1, 10'h000, 1'b0};
      tbl[1]  = '{0, CMD_READ,  9'h005, 16'h0000, 16'hBEEF, 2, 0, 10'h000, 1'b0};
      tbl[2]  = '{1, CMD_WRITE, 9'h005, 16'hBEEF, 16'h0000, 2, 1, 10'h000, 1'b0};
      tbl[3]  = '{1, CMD_READ,  9'h005, 16'h0000, 16'hBEEF, 4, 0, 10'h000, 1'b0};
      tbl[4]  = '{0, CMD_WRITE, 9'h100, 16'h03A5, 16'h0000, 2, 0, 10'h3A5, 1'b0};
      tbl[5]  = '{0, CMD_READ,  9'h100, 16'h0000, 16'h03A5, 2, 0, 10'h3A5, 1'b0};
      tbl[6]  = '{0, CMD_READ,  9'h140, 16'h0000, 16'h02C1, 2, 0, 10'h3A5, 1'b0};
      tbl[7]  = '{1, CMD_READ,  9'h140, 16'h0000, 16'h02C1, 2, 0, 10'h000, 1'b0};
      tbl[8]  = '{0, CMD_WRITE, 9'h1FF, 16'h1234, 16'h0000, 2, 0, 10'h3A5, 1'b1};
      tbl[9]  = '{0, CMD_READ,  9'h1FF, 16'h0000, 16'h0000, 2, 0, 10'h3A5, 1'b1};
      tbl[10] = '{0, CMD_READ,  9'h005, 16'h0000, 16'hBEEF, 2, 0, 10'h3A5, 1'b1};
      tbl[11] = '{1, CMD_WRITE, 9'h0FF, 16'h5A5A, 16'h0000, 2, 1, 10'h000, 1'b0};
      tbl[12] = '{1, CMD_READ,  9'h0FF, 16'h0000, 16'h5A5A, 4, 0, 10'h000, 1'b0};

      reset = 1'b0;
      sw = 10'h2C1;
      drive(0, CMD_NONE, 9'h0, 16'h0);
      drive(1, CMD_NONE, 9'h0, 16'h0);
      repeat (3) @(negedge clk);
      sample(0, rdy, rd, we, ra, rw, led, err);
      check_output("reset mem_ready", rdy, 1'b0);
      check_output("reset mem_rdata", rd, 16'h0);
      check_output("reset ram_we", we, 1'b0);
      check_output("reset ram_addr", ra, 8'h0);
      check_output("reset ledr", led, 10'h0);
      check_output("reset bus_err", err, 1'b0);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 13; i++) begin
         run_vector(tbl[i], $sformatf("vec%0d", i));
      end

      ref_led[0] = 10'h3A5; ref_err[0] = 1'b1;
      ref_led[1] = 10'h000; ref_err[1] = 1'b0;
      ref_sw = 10'h2C1;
      for (int s = 0; s < 2; s++) begin
         for (int a = 0; a < 16; a++) begin
            model_txn(s, CMD_WRITE, 9'(a), 16'($urandom), v);
            run_vector(v, $sformatf("init%0d_%0d", s, a));
         end
      end

      for (int n = 0; n < 40; n++) begin
         int cls;
         if (n % 8 == 0) begin
            @(negedge clk);
            sw = 10'($urandom);
            ref_sw = sw;
            repeat (3) @(negedge clk);
         end
         cls = $urandom_range(0, 9);
         if (cls < 5) addr = 9'($urandom_range(0, 15));
         else if (cls < 7) addr = 9'h100;
         else if (cls < 8) addr = 9'h140;
         else begin
            addr = 9'h100 | 9'($urandom_range(1, 255));
            if (addr == 9'h140) addr = 9'h1FF;
         end
         model_txn($urandom_range(0, 1), ($urandom_range(0, 1) == 0) ? CMD_READ : CMD_WRITE,
                   addr, 16'($urandom), v);
         run_vector(v, $sformatf("rand%0d", n));
      end

      // A command left asserted restarts on every IDLE edge: one pulse per 3 cycles.
      @(negedge clk);
      drive(0, CMD_READ, 9'h140, 16'h0);
      pulses = 0;
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         sample(0, rdy, rd, we, ra, rw, led, err);
         if (rdy) pulses++;
      end
      drive(0, CMD_NONE, 9'h0, 16'h0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         sample(0, rdy, rd, we, ra, rw, led, err);
         if (rdy) pulses++;
      end
      check_output("held cmd pulses", pulses, 3);

      // Reset in the middle of a latency-3 RAM read aborts it.
      @(negedge clk);
      drive(1, CMD_READ, 9'h005, 16'h0);
      @(posedge clk);
      #1 drive(1, CMD_NONE, 9'h0, 16'h0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      sample(1, rdy, rd, we, ra, rw, led, err);
      check_output("abort mem_ready", rdy, 1'b0);
      check_output("abort mem_rdata", rd, 16'h0);
      check_output("abort ram_we", we, 1'b0);
      check_output("abort ram_addr", ra, 8'h0);
      check_output("abort ram_wdata", rw, 16'h0);
      check_output("abort bus_err", err, 1'b0);
      sample(0, rdy, rd, we, ra, rw, led, err);
      check_output("abort ledr dut1", led, 10'h0);
      check_output("abort bus_err dut1", err, 1'b0);
      pulses = 0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         sample(1, rdy, rd, we, ra, rw, led, err);
         if (rdy) pulses++;
      end
      check_output("abort no ready", pulses, 0);
      ref_led[0] = 10'h0; ref_err[0] = 1'b0;
      ref_led[1] = 10'h0; ref_err[1] = 1'b0;
      model_txn(1, CMD_READ, 9'h005, 16'h0, v);
      run_vector(v, "after_reset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
